ball_centroid_collector: RTL and testbench
==========================================

// Module: ball_centroid_collector
// PURPOSE
//  Upstream feeder of the pattern-evaluation (ball matching) stage.
//  - Per video frame, accumulates pixel coordinates for each blob label 1..7 from the labelled pixel stream.
//  - At frame end, computes integer centroids with a shared sequential divider.
//  - Presents the per-ball x/y arrays with a valid/ready handshake; matching is busy for many cycles, so ready is honoured.
// PARAMETERS
//  MIN_PIXELS  16  label pixel count below this -> ball not seen this frame
//  COUNT_W     20  per-label pixel counter width (saturating)
//  SUM_W       32  per-label coordinate sum width (unsigned)
// PORTS
//  clk_in          in   1       single system clock
//  rst_in          in   1       asynchronous, active-high reset
//  new_frame_in    in   1       1-cycle pulse in blanking, marks frame boundary
//  pixel_valid_in  in   1       pixel qualifier
//  hcount_in       in   11      pixel x, 0..1279
//  vcount_in       in   10      pixel y, 0..719
//  label_in        in   3       blob label; 0 = background
//  num_balls_in    in   3       balls in pattern, 1..7; sampled on entry to ACCUM
//  ready_in        in   1       downstream accepts result
//  data_valid_out  out  1       result valid; held until ready_in
//  balls_x_out     out  11x7    centroid x, index k = label k+1
//  balls_y_out     out  10x7    centroid y
//  balls_seen_out  out  7       bit k set if label k+1 met MIN_PIXELS
//  busy_out        out  1       high in ACCUM, DIV and PRESENT
// BEHAVIOUR
//  Reset (async, any state)
//  - State -> IDLE. All outputs 0; sums, counts and divider cleared.
//  State machine
//  - IDLE: on new_frame_in -> ACCUM. Clear 7 sums_x, sums_y, counts. Latch num_balls_in.
//  - ACCUM: on pixel_valid_in with label L, 1<=L<=latched num_balls:
//    - sum_x[L] += hcount; sum_y[L] += vcount; count[L] += 1 (count saturates).
//    - Label 0 or L > num_balls: ignored.
//    - On new_frame_in -> DIV. A pixel coincident with the new_frame_in pulse is dropped.
//  - DIV: 14 divisions in fixed order L1x, L1y, L2x, ... L7y; every label runs regardless of count.
//    - Each division is 33 cycles: 1 load + 32 restoring iterations, quotient = floor(sum/count).
//    - After label L's y division: if count[L] >= MIN_PIXELS, write balls_x_out[L-1] and balls_y_out[L-1] (low 11/10 bits) and set seen bit.
//    - Otherwise the position is held from the previous frame and the seen bit is cleared.
//    - count = 0 gives quotient all-ones internally; it is always discarded because 0 < MIN_PIXELS.
//    - After 462 cycles -> PRESENT.
//  - PRESENT: data_valid_out = 1. Outputs stable while valid.
//    - Transfer occurs on the edge where valid && ready_in. Next cycle valid = 0 and state -> IDLE.
//  Latency and frame skipping
//  - data_valid_out rises exactly 463 cycles after the edge that samples the new_frame_in ending ACCUM.
//  - new_frame_in in DIV or PRESENT is ignored; that frame is skipped.
//  - Accumulation resumes at the first new_frame_in seen in IDLE.
//  - The IDLE edge that sees new_frame_in starts ACCUM; ACCUM spans exactly one frame.
//  Widths
//  - Inputs bounded to 1280x720, so max sum is 1279*921600 < 2^31 and no sum overflow is possible.
//  - Count saturates at 2^COUNT_W-1.
//  - Quotient is never larger than the maximum coordinate; truncating to 11/10 bits is exact.
// TESTING
//  1. num_balls=1; label 1 on 4x4 box x100..103, y50..53 (16 px); frame end -> 463 cycles later valid, x[0]=101, y[0]=51, seen=7'b0000001.
//  2. Label 2 with 10 px (num_balls=2) -> seen[1]=0 and x[1]/y[1] equal previous frame's values; after reset they are 0.
//  3. num_balls=3; 40 px labelled 5 -> seen[4]=0; sums for label 5 unchanged; labels 1..3 correct.
//  4. ready_in low for 2000 cycles with 3 new_frame_in pulses -> valid held, outputs stable, frames skipped; ready high -> valid drops next cycle; next new_frame_in restarts ACCUM.
//  5. rst_in asserted mid-DIV, asynchronously between edges -> all outputs 0 and busy_out=0 immediately; next new_frame_in starts a clean ACCUM.
//  6. num_balls=7; all 921600 px labelled 7 -> x[6]=639, y[6]=359, seen=7'b1000000, no overflow.

Source files
------------

// File: rtl/ball_centroid_collector.sv
// Ball centroid collector.
// Accumulates per-label coordinate sums and pixel counts over one video
// frame, then runs a shared restoring divider over all seven labels to
// produce integer centroids. Results are presented with a valid/ready
// handshake and held until the downstream matcher accepts them.
module ball_centroid_collector #(
    parameter int MIN_PIXELS = 16,
    parameter int COUNT_W    = 20,
    parameter int SUM_W      = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             new_frame_in,
    input  logic             pixel_valid_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic [2:0]       label_in,
    input  logic [2:0]       num_balls_in,
    input  logic             ready_in,
    output logic             data_valid_out,
    output logic [6:0][10:0] balls_x_out,
    output logic [6:0][9:0]  balls_y_out,
    output logic [6:0]       balls_seen_out,
    output logic             busy_out
);

    localparam int         NUM_LABELS = 7;
    localparam logic [3:0] LAST_DIV   = 4'd13;
    localparam logic [5:0] LAST_STEP  = 6'(SUM_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DIV,
        S_WRITE,
        S_PRESENT
    } state_t;

    state_t state;
    state_t state_next;

    // Frame accumulators, one entry per label 1..7 (index = label - 1).
    logic [2:0]         num_balls;
    logic [SUM_W-1:0]   sum_x [NUM_LABELS];
    logic [SUM_W-1:0]   sum_y [NUM_LABELS];
    logic [COUNT_W-1:0] count [NUM_LABELS];

    // Divider sequencing: div_idx walks L1x, L1y, ... L7y; step 0 is the load.
    logic [3:0]         div_idx;
    logic [5:0]         step;
    logic [2:0]         div_label;

    // Restoring divider datapath.
    logic [SUM_W-1:0]   rem;
    logic [SUM_W-1:0]   quo;
    logic [COUNT_W-1:0] divisor;
    logic [SUM_W:0]     rem_shift;
    logic [SUM_W:0]     rem_diff;
    logic [SUM_W-1:0]   rem_next;
    logic [SUM_W-1:0]   quo_next;
    logic [SUM_W-1:0]   load_dividend;
    logic [COUNT_W-1:0] load_divisor;

    // Finished quotients waiting to be committed to the output arrays.
    logic [10:0]        q_x_hold;
    logic [9:0]         q_y_hold;
    logic [2:0]         wb_label;
    logic               wb_pending;

    logic               pixel_hit;
    logic               div_last;

    assign div_label = div_idx[3:1];
    assign div_last  = (step == LAST_STEP) && (div_idx == LAST_DIV);
    assign pixel_hit = (state == S_ACCUM) && pixel_valid_in && !new_frame_in &&
                       (label_in != 3'd0) && (label_in <= num_balls);

    assign data_valid_out = (state == S_PRESENT);
    assign busy_out       = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: frame pulses outside IDLE/ACCUM are deliberately ignored.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:    if (new_frame_in) state_next = S_ACCUM;
            S_ACCUM:   if (new_frame_in) state_next = S_DIV;
            S_DIV:     if (div_last)     state_next = S_WRITE;
            S_WRITE:                     state_next = S_PRESENT;
            S_PRESENT: if (ready_in)     state_next = S_IDLE;
            default:                     state_next = S_IDLE;
        endcase
    end

    // Select the dividend/divisor for the division about to be loaded.
    always_comb begin
        load_dividend = '0;
        load_divisor  = '0;
        for (int k = 0; k < NUM_LABELS; k++) begin
            if (div_label == 3'(k)) begin
                load_dividend = div_idx[0] ? sum_y[k] : sum_x[k];
                load_divisor  = count[k];
            end
        end
    end

    // One restoring iteration: shift in the next dividend bit, try to subtract.
    always_comb begin
        rem_shift = {rem, quo[SUM_W-1]};
        rem_diff  = rem_shift - {{(SUM_W + 1 - COUNT_W){1'b0}}, divisor};
        rem_next  = rem_diff[SUM_W] ? rem_shift[SUM_W-1:0] : rem_diff[SUM_W-1:0];
        quo_next  = {quo[SUM_W-2:0], ~rem_diff[SUM_W]};
    end

    // Accumulation, divider sequencing and result write-back.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            num_balls      <= '0;
            div_idx        <= '0;
            step           <= '0;
            rem            <= '0;
            quo            <= '0;
            divisor        <= '0;
            q_x_hold       <= '0;
            q_y_hold       <= '0;
            wb_label       <= '0;
            wb_pending     <= 1'b0;
            balls_x_out    <= '0;
            balls_y_out    <= '0;
            balls_seen_out <= '0;
            // NOTE: these small register arrays are reset explicitly so a reset
            // mid-frame cannot leak stale sums into the next frame's centroids.
            for (int k = 0; k < NUM_LABELS; k++) begin
                sum_x[k] <= '0;
                sum_y[k] <= '0;
                count[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (new_frame_in) begin
                        num_balls <= num_balls_in;
                        for (int k = 0; k < NUM_LABELS; k++) begin
                            sum_x[k] <= '0;
                            sum_y[k] <= '0;
                            count[k] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (new_frame_in) begin
                        div_idx <= '0;
                        step    <= '0;
                    end
                    for (int k = 0; k < NUM_LABELS; k++) begin
                        if (pixel_hit && (label_in == 3'(k + 1))) begin
                            sum_x[k] <= sum_x[k] + SUM_W'(hcount_in);
                            sum_y[k] <= sum_y[k] + SUM_W'(vcount_in);
                            if (count[k] != '1) begin
                                count[k] <= count[k] + COUNT_W'(1);
                            end
                        end
                    end
                end
                S_DIV: begin
                    if (step == 6'd0) begin
                        rem     <= '0;
                        quo     <= load_dividend;
                        divisor <= load_divisor;
                        step    <= 6'd1;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        if (step == LAST_STEP) begin
                            step    <= 6'd0;
                            div_idx <= div_idx + 4'd1;
                            if (!div_idx[0]) begin
                                q_x_hold <= quo_next[10:0];
                            end else begin
                                q_y_hold   <= quo_next[9:0];
                                wb_label   <= div_label;
                                wb_pending <= 1'b1;
                            end
                        end else begin
                            step <= step + 6'd1;
                        end
                    end
                end
                default: ;
            endcase

            // Commit a finished label one cycle after its y quotient settles.
            if (wb_pending) begin
                wb_pending <= 1'b0;
                for (int k = 0; k < NUM_LABELS; k++) begin
                    if (wb_label == 3'(k)) begin
                        if (count[k] >= COUNT_W'(MIN_PIXELS)) begin
                            balls_x_out[k]    <= q_x_hold;
                            balls_y_out[k]    <= q_y_hold;
                            balls_seen_out[k] <= 1'b1;
                        end else begin
                            balls_seen_out[k] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ball_centroid_collector.sv
// Directed testbench for ball_centroid_collector.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_ball_centroid_collector;

    logic             clk = 1'b0;
    logic             rst;
    logic             new_frame;
    logic             pixel_valid;
    logic [10:0]      hcount;
    logic [9:0]       vcount;
    logic [2:0]       label;
    logic [2:0]       num_balls;
    logic             ready;
    logic             data_valid;
    logic [6:0][10:0] balls_x;
    logic [6:0][9:0]  balls_y;
    logic [6:0]       balls_seen;
    logic             busy;

    int checks = 0;
    int errors = 0;

    ball_centroid_collector dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .new_frame_in   (new_frame),
        .pixel_valid_in (pixel_valid),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .label_in       (label),
        .num_balls_in   (num_balls),
        .ready_in       (ready),
        .data_valid_out (data_valid),
        .balls_x_out    (balls_x),
        .balls_y_out    (balls_y),
        .balls_seen_out (balls_seen),
        .busy_out       (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input int x, input int y, input logic [2:0] l);
        pixel_valid = 1'b1;
        hcount      = 11'(x);
        vcount      = 10'(y);
        label       = l;
        step_clk();
        pixel_valid = 1'b0;
        label       = 3'd0;
    endtask

    task automatic send_box(input int x0, input int y0, input int w, input int h, input logic [2:0] l);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                send_pixel(x0 + i, y0 + j, l);
    endtask

    task automatic send_repeat(input int x, input int y, input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) send_pixel(x, y, l);
    endtask

    task automatic pulse_frame();
        new_frame = 1'b1;
        step_clk();
        new_frame = 1'b0;
    endtask

    // Wait for data_valid, counting edges after the frame-end edge; bounded.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (data_valid !== 1'b1 && cycles < 1000) begin
            step_clk();
            cycles++;
        end
    endtask

    task automatic accept();
        ready = 1'b1;
        step_clk();
        ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; new_frame = 1'b0; pixel_valid = 1'b0; hcount = '0; vcount = '0;
        label = '0; num_balls = '0; ready = 1'b0;
        repeat (3) step_clk();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (balls_x !== '0 || balls_y !== '0 || balls_seen !== '0) begin
            errors++; $display("FAIL reset_outputs: x=%h y=%h seen=%b expected all 0", balls_x, balls_y, balls_seen);
        end
        rst = 1'b0;
        send_repeat(10, 10, 3'd1, 5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_frame_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_ball();
        int n;
        num_balls = 3'd1;
        pulse_frame();
        num_balls = 3'd0;  // must have been latched on entry
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accum_busy: got %b expected 1", busy); end
        send_box(100, 50, 4, 4, 3'd1);
        // A pixel coincident with the closing frame pulse must be dropped.
        new_frame = 1'b1; pixel_valid = 1'b1; hcount = 11'd1279; vcount = 10'd719; label = 3'd1;
        step_clk();
        new_frame = 1'b0; pixel_valid = 1'b0; label = 3'd0;
        wait_valid(n);
        checks++; if (n != 463) begin errors++; $display("FAIL latency: got %0d expected 463", n); end
        checks++; if (balls_x[0] !== 11'd101) begin errors++; $display("FAIL single_x0: got %0d expected 101", balls_x[0]); end
        checks++; if (balls_y[0] !== 10'd51) begin errors++; $display("FAIL single_y0: got %0d expected 51", balls_y[0]); end
        checks++; if (balls_seen !== 7'b0000001) begin errors++; $display("FAIL single_seen: got %b expected 0000001", balls_seen); end
        checks++; if (balls_x[1] !== 11'd0) begin errors++; $display("FAIL single_x1: got %0d expected 0", balls_x[1]); end
        repeat (5) step_clk();
        checks++; if (data_valid !== 1'b1 || balls_x[0] !== 11'd101) begin
            errors++; $display("FAIL single_hold: valid=%b x0=%0d expected 1/101", data_valid, balls_x[0]);
        end
        accept();
        checks++; if (data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_accept: valid=%b busy=%b expected 0/0", data_valid, busy);
        end
    endtask

    task automatic test_hold_unseen();
        int n;
        num_balls = 3'd2;
        pulse_frame();
        send_box(200, 100, 4, 4, 3'd1);
        send_box(700, 400, 5, 2, 3'd2);
        pulse_frame();
        wait_valid(n);
        checks++; if (balls_seen !== 7'b0000001) begin errors++; $display("FAIL hold_f1_seen: got %b expected 0000001", balls_seen); end
        checks++; if (balls_x[0] !== 11'd201 || balls_y[0] !== 10'd101) begin
            errors++; $display("FAIL hold_f1_xy0: got %0d,%0d expected 201,101", balls_x[0], balls_y[0]);
        end
        checks++; if (balls_x[1] !== 11'd0 || balls_y[1] !== 10'd0) begin
            errors++; $display("FAIL hold_f1_xy1: got %0d,%0d expected 0,0", balls_x[1], balls_y[1]);
        end
        accept();
        pulse_frame();
        send_box(300, 200, 4, 4, 3'd2);
        pulse_frame();
        wait_valid(n);
        checks++; if (balls_seen !== 7'b0000010) begin errors++; $display("FAIL hold_f2_seen: got %b expected 0000010", balls_seen); end
        checks++; if (balls_x[1] !== 11'd301 || balls_y[1] !== 10'd201) begin
            errors++; $display("FAIL hold_f2_xy1: got %0d,%0d expected 301,201", balls_x[1], balls_y[1]);
        end
        checks++; if (balls_x[0] !== 11'd201 || balls_y[0] !== 10'd101) begin
            errors++; $display("FAIL hold_f2_xy0: got %0d,%0d expected 201,101", balls_x[0], balls_y[0]);
        end
        accept();
        pulse_frame();
        send_box(900, 600, 5, 2, 3'd2);
        pulse_frame();
        wait_valid(n);
        checks++; if (balls_seen !== 7'b0000000) begin errors++; $display("FAIL hold_f3_seen: got %b expected 0000000", balls_seen); end
        checks++; if (balls_x[1] !== 11'd301 || balls_y[1] !== 10'd201) begin
            errors++; $display("FAIL hold_f3_xy1: got %0d,%0d expected 301,201", balls_x[1], balls_y[1]);
        end
        accept();
    endtask

    task automatic test_label_range();
        int n;
        num_balls = 3'd3;
        pulse_frame();
        send_box(10, 20, 4, 4, 3'd1);
        send_box(500, 600, 4, 4, 3'd2);
        send_repeat(1000, 700, 3'd3, 16);
        send_repeat(50, 60, 3'd5, 40);
        send_repeat(1200, 10, 3'd0, 20);
        pulse_frame();
        wait_valid(n);
        checks++; if (balls_seen !== 7'b0000111) begin errors++; $display("FAIL range_seen: got %b expected 0000111", balls_seen); end
        checks++; if (balls_x[0] !== 11'd11 || balls_y[0] !== 10'd21) begin
            errors++; $display("FAIL range_xy0: got %0d,%0d expected 11,21", balls_x[0], balls_y[0]);
        end
        checks++; if (balls_x[1] !== 11'd501 || balls_y[1] !== 10'd601) begin
            errors++; $display("FAIL range_xy1: got %0d,%0d expected 501,601", balls_x[1], balls_y[1]);
        end
        checks++; if (balls_x[2] !== 11'd1000 || balls_y[2] !== 10'd700) begin
            errors++; $display("FAIL range_xy2: got %0d,%0d expected 1000,700", balls_x[2], balls_y[2]);
        end
        checks++; if (balls_x[4] !== 11'd0 || balls_y[4] !== 10'd0) begin
            errors++; $display("FAIL range_xy4: got %0d,%0d expected 0,0", balls_x[4], balls_y[4]);
        end
        accept();
    endtask

    task automatic test_back_pressure();
        int n;
        logic [6:0][10:0] sx;
        logic [6:0][9:0]  sy;
        logic [6:0]       ss;
        logic             stable;
        num_balls = 3'd1;
        pulse_frame();
        send_repeat(640, 360, 3'd1, 16);
        pulse_frame();
        wait_valid(n);
        checks++; if (balls_x[0] !== 11'd640 || balls_y[0] !== 10'd360) begin
            errors++; $display("FAIL bp_xy0: got %0d,%0d expected 640,360", balls_x[0], balls_y[0]);
        end
        sx = balls_x; sy = balls_y; ss = balls_seen;
        stable = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (i == 300 || i == 900 || i == 1500) begin
                new_frame = 1'b1;
                pixel_valid = 1'b1; hcount = 11'd5; vcount = 10'd5; label = 3'd1;
            end
            step_clk();
            new_frame = 1'b0; pixel_valid = 1'b0; label = 3'd0;
            if (data_valid !== 1'b1 || busy !== 1'b1 || balls_x !== sx || balls_y !== sy || balls_seen !== ss)
                stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b expected 1", stable); end
        accept();
        checks++; if (data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release: valid=%b busy=%b expected 0/0", data_valid, busy);
        end
        pulse_frame();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_restart_busy: got %b expected 1", busy); end
        send_repeat(7, 9, 3'd1, 16);
        pulse_frame();
        wait_valid(n);
        checks++; if (n != 463) begin errors++; $display("FAIL bp_latency: got %0d expected 463", n); end
        checks++; if (balls_x[0] !== 11'd7 || balls_y[0] !== 10'd9) begin
            errors++; $display("FAIL bp_restart_xy0: got %0d,%0d expected 7,9", balls_x[0], balls_y[0]);
        end
        accept();
    endtask

    task automatic test_async_reset();
        int n;
        num_balls = 3'd1;
        pulse_frame();
        send_repeat(30, 40, 3'd1, 16);
        pulse_frame();
        repeat (100) step_clk();
        checks++; if (balls_x[0] !== 11'd30 || busy !== 1'b1) begin
            errors++; $display("FAIL arst_pre: x0=%0d busy=%b expected 30/1", balls_x[0], busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++; $display("FAIL arst_ctrl: busy=%b valid=%b expected 0/0", busy, data_valid);
        end
        checks++; if (balls_x !== '0 || balls_y !== '0 || balls_seen !== '0) begin
            errors++; $display("FAIL arst_outputs: x=%h y=%h seen=%b expected all 0", balls_x, balls_y, balls_seen);
        end
        #3 rst = 1'b0;
        step_clk();
        num_balls = 3'd2;
        pulse_frame();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_restart_busy: got %b expected 1", busy); end
        send_repeat(20, 30, 3'd2, 16);
        pulse_frame();
        wait_valid(n);
        checks++; if (balls_seen !== 7'b0000010) begin errors++; $display("FAIL arst_seen: got %b expected 0000010", balls_seen); end
        checks++; if (balls_x[1] !== 11'd20 || balls_y[1] !== 10'd30 || balls_x[0] !== 11'd0) begin
            errors++; $display("FAIL arst_xy: x1=%0d y1=%0d x0=%0d expected 20,30,0", balls_x[1], balls_y[1], balls_x[0]);
        end
        accept();
    endtask

    task automatic test_full_range();
        int n;
        num_balls = 3'd7;
        pulse_frame();
        for (int r = 0; r < 4; r++) begin
            send_pixel(0, 0, 3'd7);
            send_pixel(1279, 719, 3'd7);
            send_pixel(1279, 0, 3'd7);
            send_pixel(0, 719, 3'd7);
        end
        send_repeat(600, 300, 3'd0, 5);
        pulse_frame();
        wait_valid(n);
        checks++; if (balls_x[6] !== 11'd639 || balls_y[6] !== 10'd359) begin
            errors++; $display("FAIL full_xy6: got %0d,%0d expected 639,359", balls_x[6], balls_y[6]);
        end
        checks++; if (balls_seen !== 7'b1000000) begin errors++; $display("FAIL full_seen: got %b expected 1000000", balls_seen); end
        checks++; if (balls_x[1] !== 11'd20) begin errors++; $display("FAIL full_hold_x1: got %0d expected 20", balls_x[1]); end
        accept();
    endtask

    initial begin
        test_reset();
        test_single_ball();
        test_hold_unseen();
        test_label_range();
        test_back_pressure();
        test_async_reset();
        test_full_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
